// File: rtl/instr_issue_unit.sv
// instr_issue_unit: upstream issue stage for the CU.
//
// Holds a DEPTH-slot program of 19-bit words, each {opcode[2:0], op1[7:0], op2[7:0]}.
// After start, the words are issued in order over a valid/ready handshake.
// Every output comes from a register. instr_valid never depends combinationally on
// instr_ready.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   load_en/load_addr/load_data  write one program slot (accepted in IDLE only)
//   prog_len                  words to issue (0..DEPTH; larger values saturate), sampled on start
//   start                     begin issuing from slot 0 (ignored while load_en=1)
//   halt_req                  abort the running program without a done pulse
//   instr_out/instr_valid/instr_ready  word handshake toward the CU
//   pc                        slot index of the word on instr_out
//   busy                      high while issuing
//   done                      one-cycle pulse after the last accepted word, or for prog_len=0
module instr_issue_unit #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [18:0]   load_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          halt_req,
    output logic [18:0]   instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t      state, state_n;
    logic [18:0] slots [DEPTH];
    logic [AW:0] len;
    logic [AW:0] len_sat;
    logic        hs, last, accept_start;

    assign len_sat      = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
    assign hs           = (state == ISSUE) && instr_valid && instr_ready;
    // len is at least 1 whenever this is used (ISSUE is only entered with len > 0).
    assign last         = ({1'b0, pc} == (len - 1'b1));
    assign accept_start = (state == IDLE) && start && !load_en;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept_start) state_n = (len_sat == '0) ? DONE : ISSUE;
            ISSUE: begin
                // halt wins over completion, so a halted last word produces no done pulse.
                if (halt_req)        state_n = IDLE;
                else if (hs && last) state_n = DONE;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
            len         <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // The done flag is high exactly while the FSM sits in DONE.
            done <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (load_en) begin
                        slots[load_addr] <= load_data;
                    end else if (start) begin
                        len <= len_sat;
                        if (len_sat != '0) begin
                            pc          <= '0;
                            instr_out   <= slots[0];
                            instr_valid <= 1'b1;
                            busy        <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (halt_req || (hs && last)) begin
                        // pc and instr_out keep their last values; only valid qualifies them.
                        instr_valid <= 1'b0;
                        busy        <= 1'b0;
                    end else if (hs) begin
                        // Fetch the next word on the accepting edge, so there is no bubble.
                        pc        <= pc + 1'b1;
                        instr_out <= slots[pc + 1'b1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Testbench for instr_issue_unit. Expected words are queued as {pc, instr} when a
// program is started. They are popped when a handshake is observed before the edge.
module tb_instr_issue_unit;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [18:0]   load_data = '0;
    logic [AW:0]   prog_len = '0;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic [18:0]   instr_out;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    instr_issue_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .prog_len(prog_len), .start(start), .halt_req(halt_req),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .pc(pc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [AW+18:0] exp_q[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, hs_cnt = 0, done_cnt = 0;
    int first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;

    // One clock with the current inputs. Outputs are sampled at the falling edge, and
    // the task returns just after the rising edge, so the caller can drive new inputs.
    task automatic step();
        logic [AW+18:0] e;
        @(negedge clk);
        if (!rst && instr_valid && instr_ready) begin
            if (hs_cnt == 0 || cyc != last_hs_cyc + 1) first_hs_cyc = cyc;
            hs_cnt++;
            last_hs_cyc = cyc;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_extra: got pc=%0d instr=%h, expected no word", pc, instr_out);
            end else begin
                e = exp_q.pop_front();
                if ({pc, instr_out} !== e) begin
                    miscompares++;
                    $display("FAIL sb_word: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                             pc, instr_out, e[AW+18:19], e[18:0]);
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [18:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic start_prog(input logic [AW:0] n);
        prog_len = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load_basic();
        load_word(4'd0, 19'h10305);
        load_word(4'd1, 19'h3F00F);
        load_word(4'd2, 19'h7AA55);
    endtask

    task automatic push_basic();
        exp_q.push_back({4'd0, 19'h10305});
        exp_q.push_back({4'd1, 19'h3F00F});
        exp_q.push_back({4'd2, 19'h7AA55});
    endtask

    // Final-state checks shared by the scenario tasks are written inline in each one.
    task automatic test_reset();
        run(2);
        vectors++;
        if ({instr_out, instr_valid, pc, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got out=%h v=%b pc=%0d busy=%b done=%b, expected all 0",
                     instr_out, instr_valid, pc, busy, done);
        end
        rst = 1'b0;
        run(1);
    endtask

    task automatic test_basic();
        int h0, d0;
        load_basic();
        push_basic();
        h0 = hs_cnt; d0 = done_cnt;
        instr_ready = 1'b1;
        start_prog(5'd3);
        run(8);
        vectors++;
        if (hs_cnt - h0 != 3) begin
            miscompares++;
            $display("FAIL basic_count: got %0d handshakes, expected 3", hs_cnt - h0);
        end
        vectors++;
        if (last_hs_cyc - first_hs_cyc != 2) begin
            miscompares++;
            $display("FAIL basic_b2b: got span %0d cycles, expected 2", last_hs_cyc - first_hs_cyc);
        end
        vectors++;
        if (done_cnt - d0 != 1 || done_cyc != last_hs_cyc + 1) begin
            miscompares++;
            $display("FAIL basic_done: got %0d pulses at cyc %0d, expected 1 at cyc %0d",
                     done_cnt - d0, done_cyc, last_hs_cyc + 1);
        end
        vectors++;
        if (instr_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL basic_end: got valid=%b busy=%b pending=%0d, expected 0/0/0",
                     instr_valid, busy, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int h0;
        push_basic();
        h0 = hs_cnt;
        instr_ready = 1'b0;
        start_prog(5'd3);
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (instr_valid !== 1'b1 || pc !== 4'd0 || instr_out !== 19'h10305) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b pc=%0d instr=%h, expected 1/0/10305",
                         i, instr_valid, pc, instr_out);
            end
        end
        instr_ready = 1'b1;
        run(6);
        vectors++;
        if (hs_cnt - h0 != 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d handshakes, %0d pending, expected 3 and 0",
                     hs_cnt - h0, exp_q.size());
        end
    endtask

    task automatic test_halt();
        int h0, d0;
        exp_q.push_back({4'd0, 19'h10305});
        exp_q.push_back({4'd1, 19'h3F00F});
        h0 = hs_cnt; d0 = done_cnt;
        instr_ready = 1'b1;
        start_prog(5'd3);
        step();                 // pc 0 accepted
        halt_req = 1'b1;
        step();                 // pc 1 accepted together with the halt
        halt_req = 1'b0;
        run(4);
        vectors++;
        if (hs_cnt - h0 != 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL halt_count: got %0d handshakes, expected 2", hs_cnt - h0);
        end
        vectors++;
        if (done_cnt != d0 || instr_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL halt_state: got done_pulses=%0d valid=%b busy=%b, expected 0/0/0",
                     done_cnt - d0, instr_valid, busy);
        end
    endtask

    task automatic test_zero_len();
        start_prog(5'd0);
        vectors++;
        if (done !== 1'b1 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_done: got done=%b valid=%b, expected 1/0", done, instr_valid);
        end
        step();
        vectors++;
        if (done !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_after: got done=%b valid=%b, expected 0/0", done, instr_valid);
        end
    endtask

    task automatic test_full_len();
        int h0, d0;
        for (int i = 0; i < DEPTH; i++) load_word(AW'(i), 19'(i));
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH; i++) exp_q.push_back({AW'(i), 19'(i)});
            h0 = hs_cnt; d0 = done_cnt;
            instr_ready = 1'b1;
            // The second pass asks for 31 words; it must saturate to DEPTH.
            start_prog(pass == 0 ? 5'd16 : 5'd31);
            run(DEPTH + 4);
            vectors++;
            if (hs_cnt - h0 != DEPTH || done_cnt - d0 != 1 || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL full_len%0d: got %0d words, %0d done pulses, expected 16 and 1",
                         pass, hs_cnt - h0, done_cnt - d0);
            end
        end
    endtask

    task automatic test_priority();
        int h0;
        instr_ready = 1'b1;
        load_en = 1'b1; load_addr = 4'd0; load_data = 19'h12345;
        prog_len = 5'd1; start = 1'b1;
        step();
        load_en = 1'b0; start = 1'b0;
        step();
        vectors++;
        if (busy !== 1'b0 || instr_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_start: got busy=%b valid=%b done=%b, expected 0/0/0",
                     busy, instr_valid, done);
        end
        exp_q.push_back({4'd0, 19'h12345});
        h0 = hs_cnt;
        start_prog(5'd1);
        run(4);
        vectors++;
        if (hs_cnt - h0 != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL prio_write: got %0d words, expected 1", hs_cnt - h0);
        end
    endtask

    task automatic test_ignore_load();
        int h0;
        load_basic();
        push_basic();
        h0 = hs_cnt;
        instr_ready = 1'b0;
        start_prog(5'd3);
        load_word(4'd1, 19'h7FFFF);
        instr_ready = 1'b1;
        run(6);
        vectors++;
        if (hs_cnt - h0 != 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ignore_load: got %0d words, %0d pending, expected 3 and 0",
                     hs_cnt - h0, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        int h0, d0;
        instr_ready = 1'b0;
        start_prog(5'd3);
        vectors++;
        if (instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre: got valid=%b, expected 1", instr_valid);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (instr_valid !== 1'b0 || pc !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_now: got valid=%b pc=%0d busy=%b, expected 0/0/0",
                     instr_valid, pc, busy);
        end
        d0 = done_cnt;
        step();
        rst = 1'b0;
        step();
        exp_q.push_back({4'd0, 19'h00000});
        h0 = hs_cnt;
        instr_ready = 1'b1;
        start_prog(5'd1);
        run(4);
        vectors++;
        if (hs_cnt - h0 != 1 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL arst_after: got %0d words, %0d done pulses, expected 1 and 1",
                     hs_cnt - h0, done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_halt();
        test_zero_len();
        test_full_len();
        test_priority();
        test_ignore_load();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
